fc1_out_wb: RTL and testbench

Write-back stage directly downstream of the fc_1 controller in the LeNet accelerator. It takes the pairs of accumulated fc1 neuron sums produced by the fc1 MAC datapath, one pair per cycle on the A and B lanes. Each sum gets ReLU, a rounded right shift and signed saturation to the feature-map width. The results are written through both ports of the fc2 input BRAM, and the block signals layer completion to the top-level sequencer.

---
 rtl/fc1_out_wb_if.sv | 37 +++
 rtl/fc1_out_wb.sv | 144 ++++++++++++++
 tb/tb_fc1_out_wb.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fc1_out_wb_if.sv
// rtl/fc1_out_wb_if.sv - accumulator input, fc2 BRAM write and status signals of the fc1 write-back stage
interface fc1_out_wb_if #(
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 8,
  parameter int ADDR_W = 7
);
  logic              fc_1_en;
  logic              acc_vld;
  logic [ACC_W-1:0]  acc_a;
  logic [ACC_W-1:0]  acc_b;
  logic              acc_rdy;
  logic              out_bram_ena;
  logic              out_bram_wea;
  logic [ADDR_W-1:0] out_bram_addra;
  logic [OUT_W-1:0]  out_bram_dina;
  logic              out_bram_enb;
  logic              out_bram_web;
  logic [ADDR_W-1:0] out_bram_addrb;
  logic [OUT_W-1:0]  out_bram_dinb;
  logic              busy;
  logic              fc_1_wb_finish;
  logic [7:0]        sat_cnt;

  modport master (
    output fc_1_en, acc_vld, acc_a, acc_b,
    input  acc_rdy, out_bram_ena, out_bram_wea, out_bram_addra, out_bram_dina,
           out_bram_enb, out_bram_web, out_bram_addrb, out_bram_dinb,
           busy, fc_1_wb_finish, sat_cnt
  );

  modport slave (
    input  fc_1_en, acc_vld, acc_a, acc_b,
    output acc_rdy, out_bram_ena, out_bram_wea, out_bram_addra, out_bram_dina,
           out_bram_enb, out_bram_web, out_bram_addrb, out_bram_dinb,
           busy, fc_1_wb_finish, sat_cnt
  );
endinterface

// File: rtl/fc1_out_wb.sv
// rtl/fc1_out_wb.sv - fc1 write-back: ReLU, rounded shift and saturation of neuron pairs into the fc2 input BRAM
module fc1_out_wb #(
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 8,
  parameter int N_OUT  = 120,
  parameter int ADDR_W = 7
) (
  input  logic       i_clk,
  input  logic       i_rst,
  fc1_out_wb_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam logic [ACC_W:0]    RND  = (ACC_W+1)'(2**(SHIFT-1));
  localparam logic [ACC_W:0]    MAXV = (ACC_W+1)'(2**(OUT_W-1)-1);
  localparam logic [ADDR_W-2:0] LAST = (ADDR_W-1)'(N_OUT/2-1);

  state_t            r_state;
  logic              r_en_d;
  logic              r_rdy;
  logic              r_busy;
  logic              r_fin;
  logic [ADDR_W-2:0] r_pair_cnt;
  logic [7:0]        r_sat;
  logic              r_s1_vld;
  logic [ACC_W:0]    r_s1_qa;
  logic [ACC_W:0]    r_s1_qb;
  logic [ADDR_W-2:0] r_s1_k;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addra;
  logic [ADDR_W-1:0] r_addrb;
  logic [OUT_W-1:0]  r_dina;
  logic [OUT_W-1:0]  r_dinb;

  logic           w_acc;
  logic [ACC_W:0] w_ra, w_rb, w_qa, w_qb;
  logic           w_clip_a, w_clip_b;
  logic [8:0]     w_sat_sum;
  logic [7:0]     w_sat_next;

  assign w_acc = bus.acc_vld & r_rdy;

  // ReLU then round-half-up; the extra MSB keeps the rounding add from overflowing
  assign w_ra = bus.acc_a[ACC_W-1] ? '0 : {1'b0, bus.acc_a} + RND;
  assign w_rb = bus.acc_b[ACC_W-1] ? '0 : {1'b0, bus.acc_b} + RND;
  assign w_qa = w_ra >> SHIFT;
  assign w_qb = w_rb >> SHIFT;

  assign w_clip_a   = r_s1_qa > MAXV;
  assign w_clip_b   = r_s1_qb > MAXV;
  assign w_sat_sum  = {1'b0, r_sat} + {8'd0, w_clip_a} + {8'd0, w_clip_b};
  assign w_sat_next = w_sat_sum[8] ? 8'hFF : w_sat_sum[7:0];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      // Treated as already high so an enable held across reset is not taken as a new edge
      r_en_d     <= 1'b1;
      r_rdy      <= 1'b0;
      r_busy     <= 1'b0;
      r_fin      <= 1'b0;
      r_pair_cnt <= '0;
      r_sat      <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_qa    <= '0;
      r_s1_qb    <= '0;
      r_s1_k     <= '0;
      r_wr       <= 1'b0;
      r_addra    <= '0;
      r_addrb    <= '0;
      r_dina     <= '0;
      r_dinb     <= '0;
    end else begin
      r_en_d <= bus.fc_1_en;
      r_fin  <= 1'b0;
      if (!bus.fc_1_en) begin
        r_state  <= S_IDLE;
        r_rdy    <= 1'b0;
        r_busy   <= 1'b0;
        r_s1_vld <= 1'b0;
        r_wr     <= 1'b0;
      end else begin
        r_s1_vld <= w_acc;
        if (w_acc) begin
          r_s1_qa <= w_qa;
          r_s1_qb <= w_qb;
          r_s1_k  <= r_pair_cnt;
        end
        r_wr <= r_s1_vld;
        if (r_s1_vld) begin
          r_addra <= {r_s1_k, 1'b0};
          r_addrb <= {r_s1_k, 1'b1};
          r_dina  <= w_clip_a ? MAXV[OUT_W-1:0] : r_s1_qa[OUT_W-1:0];
          r_dinb  <= w_clip_b ? MAXV[OUT_W-1:0] : r_s1_qb[OUT_W-1:0];
          r_sat   <= w_sat_next;
        end
        case (r_state)
          S_IDLE: begin
            if (!r_en_d) begin
              r_state    <= S_RUN;
              r_rdy      <= 1'b1;
              r_busy     <= 1'b1;
              r_pair_cnt <= '0;
              r_sat      <= '0;
            end
          end
          S_RUN: begin
            if (w_acc) begin
              if (r_pair_cnt == LAST) begin
                r_state <= S_FLUSH;
                r_rdy   <= 1'b0;
              end else begin
                r_pair_cnt <= r_pair_cnt + 1'b1;
              end
            end
          end
          S_FLUSH: begin
            // Once S1 is empty the S2 write in flight is the last one, so finish lands right after it
            if (!r_s1_vld) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_fin   <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.acc_rdy        = r_rdy;
  assign bus.out_bram_ena   = r_wr;
  assign bus.out_bram_wea   = r_wr;
  assign bus.out_bram_enb   = r_wr;
  assign bus.out_bram_web   = r_wr;
  assign bus.out_bram_addra = r_addra;
  assign bus.out_bram_addrb = r_addrb;
  assign bus.out_bram_dina  = r_dina;
  assign bus.out_bram_dinb  = r_dinb;
  assign bus.busy           = r_busy;
  assign bus.fc_1_wb_finish = r_fin;
  assign bus.sat_cnt        = r_sat;
endmodule

// File: tb/tb_fc1_out_wb.sv
// tb/tb_fc1_out_wb.sv - directed-vector bench for fc1_out_wb
module tb_fc1_out_wb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  fc1_out_wb_if #(.ACC_W(32), .OUT_W(8), .ADDR_W(7)) bus ();

  fc1_out_wb #(.ACC_W(32), .OUT_W(8), .SHIFT(8), .N_OUT(120), .ADDR_W(7)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [6:0] aa;
    logic [7:0] da;
    logic [6:0] ab;
    logic [7:0] db;
    logic       enb;
    logic       wea;
    logic       web;
  } wr_t;

  wr_t  wq[$];
  int   fin_q[$];
  logic fin_busy_q[$];
  int   acc_q[$];

  always @(negedge clk) begin
    if (bus.out_bram_ena)
      wq.push_back('{cyc, bus.out_bram_addra, bus.out_bram_dina, bus.out_bram_addrb,
                     bus.out_bram_dinb, bus.out_bram_enb, bus.out_bram_wea, bus.out_bram_web});
    if (bus.fc_1_wb_finish) begin
      fin_q.push_back(cyc);
      fin_busy_q.push_back(bus.busy);
    end
  end

  task automatic clear_logs();
    wq.delete();
    fin_q.delete();
    fin_busy_q.delete();
    acc_q.delete();
  endtask

  // Called at a negedge; returns at the negedge of cycle e+1
  task automatic start_image();
    bus.fc_1_en = 1'b0;
    bus.acc_vld = 1'b0;
    @(negedge clk);
    clear_logs();
    bus.fc_1_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic v);
    bus.acc_vld = v;
    bus.acc_a   = a;
    bus.acc_b   = b;
    if (v && bus.acc_rdy) acc_q.push_back(cyc);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.acc_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.fc_1_en = 1'b0;
    bus.acc_vld = 1'b0;
    bus.acc_a   = '0;
    bus.acc_b   = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.acc_rdy, bus.out_bram_ena, bus.out_bram_enb, bus.busy, bus.fc_1_wb_finish} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 00000", {bus.acc_rdy, bus.out_bram_ena, bus.out_bram_enb, bus.busy, bus.fc_1_wb_finish});
    end
    n_vec++;
    if ({bus.out_bram_addra, bus.out_bram_addrb, bus.out_bram_dina, bus.out_bram_dinb, bus.sat_cnt} !== 38'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", {bus.out_bram_addra, bus.out_bram_addrb, bus.out_bram_dina, bus.out_bram_dinb, bus.sat_cnt});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.acc_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy=%b rdy=%b want 0 0", bus.busy, bus.acc_rdy);
    end
  endtask

  task automatic test_full_image();
    start_image();
    n_vec++;
    if (bus.acc_rdy !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_rdy_after_edge: rdy=%b busy=%b want 1 1", bus.acc_rdy, bus.busy);
    end
    for (int k = 0; k < 60; k++) send(32'(256 * k), 32'hFFFF_FFFB, 1'b1);
    idle(6);
    n_vec++;
    if (wq.size() != 60) begin
      n_fail++;
      $display("FAIL full_write_count: got %0d want 60", wq.size());
    end
    n_vec++;
    if (acc_q.size() != 60) begin
      n_fail++;
      $display("FAIL full_accept_count: got %0d want 60", acc_q.size());
    end
    for (int i = 0; i < 60 && i < wq.size() && i < acc_q.size(); i++) begin
      n_vec++;
      if (wq[i].aa !== 7'(2 * i) || wq[i].ab !== 7'(2 * i + 1) || wq[i].da !== 8'(i) || wq[i].db !== 8'd0 ||
          {wq[i].enb, wq[i].wea, wq[i].web} !== 3'b111 || wq[i].cyc != acc_q[i] + 2) begin
        n_fail++;
        $display("FAIL full_write_%0d: got addr %0d/%0d din %0d/%0d cyc %0d want addr %0d/%0d din %0d/0 cyc %0d",
                 i, wq[i].aa, wq[i].ab, wq[i].da, wq[i].db, wq[i].cyc, 2 * i, 2 * i + 1, i, acc_q[i] + 2);
      end
    end
    n_vec++;
    if (fin_q.size() != 1) begin
      n_fail++;
      $display("FAIL full_finish_count: got %0d want 1", fin_q.size());
    end else if (acc_q.size() == 60) begin
      n_vec++;
      if (fin_q[0] != acc_q[59] + 3 || fin_busy_q[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL full_finish_time: got cyc %0d busy %b want cyc %0d busy 0", fin_q[0], fin_busy_q[0], acc_q[59] + 3);
      end
    end
    n_vec++;
    if (bus.sat_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL full_sat_cnt: got %0d want 0", bus.sat_cnt);
    end
  endtask

  task automatic test_enable_hold();
    send(32'd1000, 32'd1000, 1'b1);
    idle(10);
    n_vec++;
    if (fin_q.size() != 1 || wq.size() != 60 || bus.busy !== 1'b0 || bus.acc_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_single_finish: finishes %0d writes %0d busy %b rdy %b want 1 60 0 0",
               fin_q.size(), wq.size(), bus.busy, bus.acc_rdy);
    end
  endtask

  task automatic test_round_sat();
    logic [31:0] ta[5];
    logic [31:0] tb[5];
    logic [7:0]  ea[5];
    logic [7:0]  eb[5];
    ta = '{32'd383, 32'd384, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    tb = '{32'd32767, 32'd0, 32'hFFFF_FFFF, 32'd32639, 32'h7FFF_FFFF};
    ea = '{8'd1, 8'd2, 8'd127, 8'd0, 8'd127};
    eb = '{8'd127, 8'd0, 8'd0, 8'd127, 8'd127};
    start_image();
    n_vec++;
    if (bus.sat_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL round_sat_clear: got %0d want 0", bus.sat_cnt);
    end
    for (int i = 0; i < 5; i++) send(ta[i], tb[i], 1'b1);
    idle(4);
    n_vec++;
    if (wq.size() != 5) begin
      n_fail++;
      $display("FAIL round_write_count: got %0d want 5", wq.size());
    end
    for (int i = 0; i < 5 && i < wq.size(); i++) begin
      n_vec++;
      if (wq[i].da !== ea[i] || wq[i].db !== eb[i] || wq[i].aa !== 7'(2 * i) || wq[i].ab !== 7'(2 * i + 1)) begin
        n_fail++;
        $display("FAIL round_pair_%0d: got din %0d/%0d addr %0d/%0d want din %0d/%0d addr %0d/%0d",
                 i, wq[i].da, wq[i].db, wq[i].aa, wq[i].ab, ea[i], eb[i], 2 * i, 2 * i + 1);
      end
    end
    n_vec++;
    if (bus.sat_cnt !== 8'd4) begin
      n_fail++;
      $display("FAIL round_sat_cnt: got %0d want 4", bus.sat_cnt);
    end
  endtask

  task automatic test_bubbles();
    int j;
    start_image();
    j = 0;
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 0 || i % 4 == 3) begin
        send(32'(256 * j + 64), 32'(512 * j), 1'b1);
        j++;
      end else begin
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      end
    end
    idle(4);
    n_vec++;
    if (wq.size() != 6 || acc_q.size() != 6) begin
      n_fail++;
      $display("FAIL bubble_count: got writes %0d accepts %0d want 6 6", wq.size(), acc_q.size());
    end
    for (int i = 0; i < 6 && i < wq.size() && i < acc_q.size(); i++) begin
      n_vec++;
      if (wq[i].cyc != acc_q[i] + 2 || wq[i].aa !== 7'(2 * i) || wq[i].ab !== 7'(2 * i + 1) ||
          wq[i].da !== 8'(i) || wq[i].db !== 8'(2 * i)) begin
        n_fail++;
        $display("FAIL bubble_write_%0d: got cyc %0d addr %0d/%0d din %0d/%0d want cyc %0d addr %0d/%0d din %0d/%0d",
                 i, wq[i].cyc, wq[i].aa, wq[i].ab, wq[i].da, wq[i].db, acc_q[i] + 2, 2 * i, 2 * i + 1, i, 2 * i);
      end
    end
    n_vec++;
    if (fin_q.size() != 0) begin
      n_fail++;
      $display("FAIL bubble_no_finish: got %0d want 0", fin_q.size());
    end
  endtask

  task automatic test_abort();
    int drop_cyc;
    logic [7:0] sat_before;
    start_image();
    for (int k = 0; k < 30; k++) send(32'(256 * k), 32'h7FFF_FFFF, 1'b1);
    bus.acc_vld = 1'b0;
    bus.fc_1_en = 1'b0;
    drop_cyc = cyc;
    idle(6);
    n_vec++;
    if (wq.size() < 28 || wq.size() > 30) begin
      n_fail++;
      $display("FAIL abort_write_count: got %0d want 28..30", wq.size());
    end
    for (int i = 0; i < wq.size(); i++) begin
      n_vec++;
      if (wq[i].cyc > drop_cyc + 2 || wq[i].aa !== 7'(2 * i) || wq[i].da !== 8'(i) || wq[i].db !== 8'd127) begin
        n_fail++;
        $display("FAIL abort_write_%0d: got cyc %0d addr %0d din %0d/%0d want cyc<=%0d addr %0d din %0d/127",
                 i, wq[i].cyc, wq[i].aa, wq[i].da, wq[i].db, drop_cyc + 2, 2 * i, i);
      end
    end
    n_vec++;
    if (fin_q.size() != 0 || bus.busy !== 1'b0 || bus.acc_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: finishes %0d busy %b rdy %b want 0 0 0", fin_q.size(), bus.busy, bus.acc_rdy);
    end
    n_vec++;
    if (bus.sat_cnt !== 8'(wq.size())) begin
      n_fail++;
      $display("FAIL abort_sat_hold: got %0d want %0d", bus.sat_cnt, wq.size());
    end
    sat_before = bus.sat_cnt;
    start_image();
    n_vec++;
    if (bus.sat_cnt !== 8'd0 || bus.acc_rdy !== 1'b1 || sat_before === 8'd0) begin
      n_fail++;
      $display("FAIL abort_restart_clear: sat %0d (was %0d) rdy %b want 0 (nonzero) 1", bus.sat_cnt, sat_before, bus.acc_rdy);
    end
    send(32'd1000, 32'hFFFF_FFFF, 1'b1);
    idle(4);
    n_vec++;
    if (wq.size() != 1) begin
      n_fail++;
      $display("FAIL abort_restart_count: got %0d want 1", wq.size());
    end else begin
      n_vec++;
      if (wq[0].aa !== 7'd0 || wq[0].ab !== 7'd1 || wq[0].da !== 8'd4 || wq[0].db !== 8'd0) begin
        n_fail++;
        $display("FAIL abort_restart_write: got addr %0d/%0d din %0d/%0d want 0/1 4/0",
                 wq[0].aa, wq[0].ab, wq[0].da, wq[0].db);
      end
    end
  endtask

  task automatic test_async_reset();
    start_image();
    for (int k = 0; k < 10; k++) send(32'h7FFF_FFFF, 32'(256 * k), 1'b1);
    bus.acc_vld = 1'b1;
    n_vec++;
    if (bus.busy !== 1'b1 || bus.out_bram_ena !== 1'b1 || bus.sat_cnt === 8'd0) begin
      n_fail++;
      $display("FAIL async_pre_active: busy %b ena %b sat %0d want 1 1 nonzero", bus.busy, bus.out_bram_ena, bus.sat_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.acc_rdy, bus.out_bram_ena, bus.out_bram_wea, bus.out_bram_enb, bus.out_bram_web,
         bus.busy, bus.fc_1_wb_finish} !== 7'b0) begin
      n_fail++;
      $display("FAIL async_ctl_zero: got %b want 0000000", {bus.acc_rdy, bus.out_bram_ena, bus.out_bram_wea,
               bus.out_bram_enb, bus.out_bram_web, bus.busy, bus.fc_1_wb_finish});
    end
    n_vec++;
    if ({bus.out_bram_addra, bus.out_bram_addrb, bus.out_bram_dina, bus.out_bram_dinb, bus.sat_cnt} !== 38'b0) begin
      n_fail++;
      $display("FAIL async_data_zero: got %h want 0",
               {bus.out_bram_addra, bus.out_bram_addrb, bus.out_bram_dina, bus.out_bram_dinb, bus.sat_cnt});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wq.delete();
    repeat (8) @(negedge clk);
    n_vec++;
    if (wq.size() != 0 || bus.busy !== 1'b0 || bus.acc_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_quiet_after_release: writes %0d busy %b rdy %b want 0 0 0", wq.size(), bus.busy, bus.acc_rdy);
    end
    start_image();
    send(32'd640, 32'd0, 1'b1);
    idle(4);
    n_vec++;
    if (wq.size() != 1 || (wq.size() == 1 && (wq[0].aa !== 7'd0 || wq[0].da !== 8'd3))) begin
      n_fail++;
      $display("FAIL async_restart: writes %0d want 1 at addr 0 din 3", wq.size());
    end
  endtask

  initial begin
    bus.fc_1_en = 1'b0;
    bus.acc_vld = 1'b0;
    bus.acc_a   = '0;
    bus.acc_b   = '0;
    @(negedge clk);
    test_reset();
    test_full_image();
    test_enable_hold();
    test_round_sat();
    test_bubbles();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
